// File: rtl/addsub_arbiter.sv
// Two-requester round-robin front end sharing one ripple add/sub datapath.
// Each operation is granted in IDLE, computed in EXEC and held in HOLD until consumed.

module addsub32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        sub_i,
   output logic [31:0] ans_o,
   output logic        cout_o,
   output logic        v_o
);

   logic [31:0] bEff;
   logic        carry;
   logic        c31;

   // Ripple chain; subtraction is A + ~B + 1 with the +1 entering as carry-in.
   always_comb begin
      bEff  = b_i ^ {32{sub_i}};
      carry = sub_i;
      c31   = 1'b0;
      ans_o = '0;
      for (int i = 0; i < 32; i++) begin
         ans_o[i] = a_i[i] ^ bEff[i] ^ carry;
         if (i == 31) begin
            c31 = carry;
         end
         carry = (a_i[i] & bEff[i]) | (carry & (a_i[i] ^ bEff[i]));
      end
      cout_o = carry;
      v_o    = carry ^ c31;
   end

endmodule

module addsub_arbiter (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_sub,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_sub,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_ans,
   output logic        rsp_cout,
   output logic        rsp_v,
   output logic [7:0]  ovf_count
);

   typedef enum logic [1:0] {
      IDLE,
      EXEC,
      HOLD
   } state_t;

   state_t      state_q;
   logic        lastGrant_q;
   logic [31:0] opA_q;
   logic [31:0] opB_q;
   logic        opSub_q;
   logic        opId_q;
   logic        rspValid_q;
   logic        rspId_q;
   logic [31:0] rspAns_q;
   logic        rspCout_q;
   logic        rspV_q;
   logic [7:0]  ovfCount_q;
   logic [7:0]  ovfCount_d;

   logic        grant0;
   logic        grant1;
   logic [31:0] dpAns;
   logic        dpCout;
   logic        dpV;

   addsub32 u_addsub32 (
      .a_i    (opA_q),
      .b_i    (opB_q),
      .sub_i  (opSub_q),
      .ans_o  (dpAns),
      .cout_o (dpCout),
      .v_o    (dpV)
   );

   // A lone requester always wins; on a tie the one not served last time wins.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (state_q == IDLE && !rst) begin
         grant0 = req0_valid & (~req1_valid | lastGrant_q);
         grant1 = req1_valid & (~req0_valid | ~lastGrant_q);
      end
   end

   always_comb begin
      ovfCount_d = ovfCount_q;
      if (rspV_q && ovfCount_q != 8'hFF) begin
         ovfCount_d = ovfCount_q + 8'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         lastGrant_q <= 1'b1;
         opA_q       <= '0;
         opB_q       <= '0;
         opSub_q     <= 1'b0;
         opId_q      <= 1'b0;
         rspValid_q  <= 1'b0;
         rspId_q     <= 1'b0;
         rspAns_q    <= '0;
         rspCout_q   <= 1'b0;
         rspV_q      <= 1'b0;
         ovfCount_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant0 || grant1) begin
                  opA_q       <= grant1 ? req1_a : req0_a;
                  opB_q       <= grant1 ? req1_b : req0_b;
                  opSub_q     <= grant1 ? req1_sub : req0_sub;
                  opId_q      <= grant1;
                  lastGrant_q <= grant1;
                  state_q     <= EXEC;
               end
            end
            EXEC: begin
               rspAns_q   <= dpAns;
               rspCout_q  <= dpCout;
               rspV_q     <= dpV;
               rspId_q    <= opId_q;
               rspValid_q <= 1'b1;
               state_q    <= HOLD;
            end
            HOLD: begin
               // Response fields stay frozen until the consumer takes them.
               if (rsp_ready) begin
                  rspValid_q <= 1'b0;
                  ovfCount_q <= ovfCount_d;
                  state_q    <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign req0_ready = grant0;
   assign req1_ready = grant1;
   assign rsp_valid  = rspValid_q;
   assign rsp_id     = rspId_q;
   assign rsp_ans    = rspAns_q;
   assign rsp_cout   = rspCout_q;
   assign rsp_v      = rspV_q;
   assign ovf_count  = ovfCount_q;

endmodule

// File: doc/addsub_arbiter.md
ADDSUB_ARBITER -- requirements
Module: addsub_arbiter

Interface
Parameters: none.
REQ-001 The block SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-002 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-003 The block SHALL have ports req0_valid / req1_valid, input, 1, requester n has an operation pending.
REQ-004 The block SHALL have ports req0_ready / req1_ready, output, 1, operation of requester n accepted this cycle.
REQ-005 The block SHALL have ports req0_a, req0_b / req1_a, req1_b, input, 32, operands A and B of requester n.
REQ-006 The block SHALL have ports req0_sub / req1_sub, input, 1, 1 = A-B, 0 = A+B.
REQ-007 The block SHALL have port rsp_valid, output, 1, result available.
REQ-008 The block SHALL have port rsp_ready, input, 1, consumer takes the result.
REQ-009 The block SHALL have port rsp_id, output, 1, index of the requester that owns the result.
REQ-010 The block SHALL have port rsp_ans, output, 32, sum/difference.
REQ-011 The block SHALL have ports rsp_cout / rsp_v, output, 1 each, carry out of bit 31 and signed overflow (C31 xor C32).
REQ-012 The block SHALL have port ovf_count, output, 8, saturating count of delivered results with rsp_v=1.
REQ-013 The block SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-014 The block SHALL contain exactly one instance of the team's 32-bit ripple add/sub datapath (addsub32), shared by both requesters.
REQ-015 The FSM SHALL have states IDLE, EXEC and HOLD.
REQ-016 IDLE: if any reqN_valid=1, grant one requester, assert its reqN_ready combinationally this cycle, latch its A, B, SUB and id into operand registers at the edge, and go to EXEC.
REQ-017 IDLE with no valid request: stay in IDLE; both ready outputs 0.
REQ-018 Arbitration SHALL be round-robin.
REQ-019 If only one requester is valid, it wins.
REQ-020 If both are valid, the requester not granted last time wins.
REQ-021 The last_grant pointer SHALL update only on a grant.
REQ-022 At most one reqN_ready SHALL be high in any cycle.
REQ-023 reqN_ready SHALL be 0 in EXEC and HOLD.
REQ-024 EXEC: the datapath SHALL take its inputs from the operand registers; ans, cout and V SHALL be registered into rsp_* at the edge; then go to HOLD.
REQ-025 EXEC SHALL last exactly 1 cycle.
REQ-026 HOLD: rsp_valid SHALL be 1.
REQ-027 rsp_id, rsp_ans, rsp_cout and rsp_v SHALL be stable until the cycle in which rsp_ready=1.
REQ-028 In that cycle the FSM SHALL go to IDLE and rsp_valid SHALL drop at the next edge.
REQ-029 Latency: the grant at edge N SHALL yield rsp_valid=1 in the cycle after edge N+1.
REQ-030 Minimum throughput SHALL be one operation per 3 cycles.
REQ-031 rsp_ready=1 while rsp_valid=0 SHALL be ignored.
REQ-032 No request SHALL be accepted in the same cycle as a response handshake.
REQ-033 rsp_valid SHALL be 0 in IDLE and EXEC.
REQ-034 ovf_count SHALL increment by 1 on each response handshake with rsp_v=1.
REQ-035 ovf_count SHALL saturate at 0xFF and never wrap to 0.
REQ-036 Arithmetic SHALL be modulo 2^32, with cout and V as defined for addsub32.
REQ-037 Subtraction SHALL be computed as A + ~B + 1.
REQ-038 Requesters SHALL hold valid and operands stable until ready; the block SHALL NOT check this.

Reset
REQ-039 On rst=1 the FSM SHALL go to IDLE and last_grant SHALL be set to 1, so req0 wins the first tie.
REQ-040 On rst=1 rsp_valid, rsp_id, rsp_cout, rsp_v, ovf_count, rsp_ans and the operand registers SHALL be set to 0.
REQ-041 Reset asserted mid-operation (EXEC or HOLD) SHALL discard the operation with no response.
REQ-042 Both ready outputs SHALL be 0 while rst=1.

Verification
REQ-043 The bench SHALL cover: req0 A=0x00000021 B=0x00000022 SUB=0, rsp_ready=1 -> req0_ready in cycle 0, rsp_valid in cycle 2, ans=0x00000043, cout=0, V=0, id=0.
REQ-044 The bench SHALL cover: both valid after reset, req0 0x7FFFFFFF+0x00000001, req1 0x336FB7E5-0x336FB7E5 -> first response id=0, ans=0x80000000, V=1; second response id=1, ans=0x00000000, cout=1, V=0; ovf_count=1.
REQ-045 The bench SHALL cover: rsp_ready held 0 for 5 cycles in HOLD with req1 valid -> rsp_* stable, req1_ready=0 throughout; after the handshake req1 is granted on the next IDLE cycle.
REQ-046 The bench SHALL cover: both requesters continuously valid for 6 operations -> grants alternate 0,1,0,1,0,1, one grant every 3 cycles.
REQ-047 The bench SHALL cover: 300 back-to-back 0x80000000-0x00000001 (V=1) results -> ovf_count stops at 0xFF.
REQ-048 The bench SHALL cover: rst pulsed during EXEC -> rsp_valid never rises for that operation, all outputs 0, the next tie goes to req0.
